// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sevenseg_pkg : shared segment width, active-low glyph constants, hex decode
// Rev 1.0
// ---------------------------------------------------------------------------
package sevenseg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'b1100000;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'b0110001;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'b1000010;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'b0111000;

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
    logic [SEG_W-1:0] glyph;
    case (nibble)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hA:    glyph = GLYPH_A;
      4'hB:    glyph = GLYPH_B;
      4'hC:    glyph = GLYPH_C;
      4'hD:    glyph = GLYPH_D;
      4'hE:    glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
    return glyph;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_scan_driver_dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hex_to_seg_dec : combinational 4-to-7 active-low hex glyph decoder
// Rev 1.0
// ---------------------------------------------------------------------------
module hex_to_seg_dec
  import sevenseg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule
`default_nettype wire

// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sevenseg_scan_driver : multiplexed N-digit 7-seg driver, blanking + frame snapshot
// Rev 1.0
// ---------------------------------------------------------------------------
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 262144,
  parameter int BLANK_CYCLES = 1024,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             INV       = (ACTIVE_LOW == 0);

  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] digits_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   en_sh;
  logic                    in_blank;
  logic                    dig_on;
  logic                    shadow_load;
  logic                    frame_head;
  logic [3:0]              nibble;
  logic [SEG_W-1:0]        glyph;
  logic [SEG_W-1:0]        seg_al;
  logic                    dp_al;
  logic [NUM_DIGITS-1:0]   an_al;

  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign in_blank = (cnt < CNT_W'(BLANK_CYCLES));
    end else begin : g_no_blank
      assign in_blank = 1'b0;
    end
  endgenerate

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    idx_nxt = idx;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx == '0) ? IDX_FIRST : idx - 1'b1;
    end
  end

  // Entering the first slot of a frame is the only time new inputs are sampled.
  assign shadow_load = (cnt_nxt == '0) && (idx_nxt == IDX_FIRST);
  assign frame_head  = (cnt == '0) && (idx == IDX_FIRST);

  assign nibble = digits_sh[4*idx +: 4];

  hex_to_seg_dec u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    dig_on = !in_blank && en_sh[idx];
    seg_al = dig_on ? glyph : SEG_OFF;
    dp_al  = !(dig_on && dp_sh[idx]);
    an_al  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_on && (idx == IDX_W'(i))) begin
        an_al[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt         <= '0;
      idx         <= IDX_FIRST;
      digits_sh   <= digits_in;
      dp_sh       <= dp_in;
      en_sh       <= digit_en;
      seg         <= SEG_OFF ^ {SEG_W{INV}};
      dp          <= 1'b1 ^ INV;
      an          <= {NUM_DIGITS{1'b1 ^ INV}};
      frame_start <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      if (shadow_load) begin
        digits_sh <= digits_in;
        dp_sh     <= dp_in;
        en_sh     <= digit_en;
      end
      seg         <= seg_al ^ {SEG_W{INV}};
      dp          <= dp_al ^ INV;
      an          <= an_al ^ {NUM_DIGITS{INV}};
      frame_start <= frame_head;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sevenseg_scan_driver : table + scoreboard bench, active-low and active-high builds
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;

  logic [6:0]  seg_l, seg_h;
  logic        dp_l, dp_h;
  logic [3:0]  an_l, an_h;
  logic        fs_l, fs_h;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .NUM_DIGITS(4), .DIGIT_CYCLES(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
  ) dut_lo (
    .clk(clk), .clr(clr), .digits_in(digits_in), .dp_in(dp_in), .digit_en(digit_en),
    .seg(seg_l), .dp(dp_l), .an(an_l), .frame_start(fs_l)
  );

  sevenseg_scan_driver #(
    .NUM_DIGITS(4), .DIGIT_CYCLES(8), .BLANK_CYCLES(2), .ACTIVE_LOW(0)
  ) dut_hi (
    .clk(clk), .clr(clr), .digits_in(digits_in), .dp_in(dp_in), .digit_en(digit_en),
    .seg(seg_h), .dp(dp_h), .an(an_h), .frame_start(fs_h)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  // Per-digit expectations indexed by digit number ([3] = leftmost, scanned first).
  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      en;
    logic [3:0]      dpi;
    logic [3:0][3:0] an;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];
  exp_t q [$];

  task automatic drive_vec(input int v);
    digits_in = vecs[v].digits;
    digit_en  = vecs[v].en;
    dp_in     = vecs[v].dpi;
  endtask

  task automatic push_frame(input int v);
    exp_t e;
    for (int d = 3; d >= 0; d--) begin
      for (int c = 0; c < 8; c++) begin
        e.fs = (d == 3) && (c == 0);
        if (c < 2) begin
          e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
        end else begin
          e.an = vecs[v].an[d]; e.seg = vecs[v].seg[d]; e.dp = vecs[v].dpo[d];
        end
        q.push_back(e);
      end
    end
  endtask

  task automatic cmp(input string name, input exp_t act, input exp_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got an=%b seg=%b dp=%b fs=%b, want an=%b seg=%b dp=%b fs=%b",
               name, act.an, act.seg, act.dp, act.fs, req.an, req.seg, req.dp, req.fs);
    end
  endtask

  task automatic check_both(input string name, input exp_t e);
    exp_t inv;
    inv = '{an: ~e.an, seg: ~e.seg, dp: ~e.dp, fs: e.fs};
    cmp({name, "_lo"}, '{an: an_l, seg: seg_l, dp: dp_l, fs: fs_l}, e);
    cmp({name, "_hi"}, '{an: an_h, seg: seg_h, dp: dp_h, fs: fs_h}, inv);
  endtask

  task automatic check_pop(input int f, input int fc);
    exp_t e;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: frame %0d cycle %0d has no expectation", f, fc);
    end else begin
      e = q.pop_front();
      check_both($sformatf("scan_f%0d_c%0d", f, fc), e);
    end
  endtask

  localparam exp_t IDLE = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fs: 1'b0};

  initial begin
    vecs[0] = '{16'h1234, 4'b1111, 4'b0000,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111};
    vecs[1] = '{16'hABCD, 4'b1111, 4'b0000,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}, 4'b1111};
    vecs[2] = '{16'hEF00, 4'b1111, 4'b0000,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0110000, 7'b0111000, 7'b0000001, 7'b0000001}, 4'b1111};
    vecs[3] = '{16'h5678, 4'b1111, 4'b0000,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}, 4'b1111};
    // digits 3 and 1 disabled: dark, and the dp_in[1] request is suppressed.
    vecs[4] = '{16'h9876, 4'b0101, 4'b0011,
                {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                {7'b1111111, 7'b0000000, 7'b1111111, 7'b0100000}, 4'b1110};
    vecs[5] = vecs[0];

    drive_vec(0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_both($sformatf("reset_%0d", i), IDLE);
    end

    push_frame(0);
    clr = 1'b0;

    // Next frame's inputs change mid-frame (second slot) to prove the snapshot.
    begin : main_scan
      for (int f = 0; f < NV; f++) begin
        for (int fc = 0; fc < 32; fc++) begin
          @(posedge clk); #1;
          check_pop(f, fc);
          if (fc == 10 && f + 1 < NV) begin
            drive_vec(f + 1);
            push_frame(f + 1);
          end
          if (f == NV - 1 && fc == 18) disable main_scan;
        end
      end
    end

    // Mid-slot clear during digit 1's active phase.
    clr = 1'b1;
    q.delete();
    @(posedge clk); #1;
    check_both("clr_mid", IDLE);
    @(posedge clk); #1;
    check_both("clr_hold", IDLE);
    clr = 1'b0;
    @(posedge clk); #1;
    check_both("restart_fs", '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fs: 1'b1});
    @(posedge clk); #1;
    check_both("restart_blank", IDLE);
    @(posedge clk); #1;
    check_both("restart_d3", '{an: 4'b0111, seg: 7'b1001111, dp: 1'b1, fs: 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
